// File: rtl/drw_cmd_pkg.sv
// rtl/drw_cmd_pkg.sv - opcode, error-code and state definitions for the draw command parser
// Contents:
//   drw_op_e         draw opcodes as they appear in header bits [31:24]
//   drw_state_e      parser FSM states
//   DRW_ERR_*        codes reported on DRW_ERR
//   drw_arg_count()  number of argument words following a header
//   drw_op_illegal() true for any opcode outside drw_op_e

package drw_cmd_pkg;

    typedef enum logic [7:0] {
        OP_NOP      = 8'h00,
        OP_SETFRAME = 8'h01,
        OP_SETCOLOR = 8'h02,
        OP_PATBLT   = 8'h03,
        OP_BITBLT   = 8'h04,
        OP_EODL     = 8'h0F
    } drw_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ARG,
        ST_ISSUE,
        ST_DRAIN,
        ST_ERROR
    } drw_state_e;

    localparam logic [2:0] DRW_ERR_OK      = 3'b000;
    localparam logic [2:0] DRW_ERR_ILLEGAL = 3'b001;
    localparam logic [2:0] DRW_ERR_TIMEOUT = 3'b010;

    function automatic logic [1:0] drw_arg_count(input logic [7:0] op);
        logic [1:0] n;
        n = 2'd0;
        case (op)
            OP_SETFRAME: n = 2'd2;
            OP_PATBLT:   n = 2'd2;
            OP_BITBLT:   n = 2'd3;
            default:     n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic drw_op_illegal(input logic [7:0] op);
        logic bad;
        bad = 1'b1;
        case (op)
            OP_NOP, OP_SETFRAME, OP_SETCOLOR,
            OP_PATBLT, OP_BITBLT, OP_EODL: bad = 1'b0;
            default:                       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/drw_cmdparse.sv
// rtl/drw_cmdparse.sv - draw command parser between the command FIFO and the draw engine
// Optional feature macro: DRW_CMDPARSE_TIMEOUT_EN (fetch stall timeout, error code 010).
// Ports:
//   CLK, ARST          clock, synchronous active-high reset
//   SOFT_RST           soft reset pulse, same effect as ARST
//   DRW_START          start pulse, honoured only in IDLE
//   CMD_FIFO_EMPTY     FIFO empty
//   CMD_FIFO_RDATA     FIFO head word (first-word-fall-through)
//   CMD_FIFO_RD        pop strobe
//   CMD_VALID/READY    command handshake to the draw engine
//   CMD_OP, CMD_IMM    decoded header fields
//   CMD_ARG0..2        argument words, unused ones read 0
//   ENGINE_BUSY        draw engine still executing
//   DRW_BUSY           parser active
//   DRW_IRQ            one-cycle completion/error pulse
//   DRW_ERR            000 ok, 001 illegal opcode, 010 fetch timeout

module drw_cmdparse
    import drw_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        CLK,
    input  logic        ARST,
    input  logic        SOFT_RST,
    input  logic        DRW_START,
    input  logic        CMD_FIFO_EMPTY,
    input  logic [31:0] CMD_FIFO_RDATA,
    output logic        CMD_FIFO_RD,
    output logic        CMD_VALID,
    input  logic        CMD_READY,
    output logic [7:0]  CMD_OP,
    output logic [23:0] CMD_IMM,
    output logic [31:0] CMD_ARG0,
    output logic [31:0] CMD_ARG1,
    output logic [31:0] CMD_ARG2,
    input  logic        ENGINE_BUSY,
    output logic        DRW_BUSY,
    output logic        DRW_IRQ,
    output logic [2:0]  DRW_ERR
);

    drw_state_e  state_q, state_d;
    logic [7:0]  op_q;
    logic [23:0] imm_q;
    logic [31:0] arg0_q, arg1_q, arg2_q;
    logic [1:0]  arg_idx_q;
    logic [1:0]  arg_cnt_q;
    logic [2:0]  err_q, err_d;

    logic        fetching;
    logic        pop;
    logic        timeout;
    logic [7:0]  hdr_op;
    logic        rst;

    assign rst      = ARST | SOFT_RST;
    assign hdr_op   = CMD_FIFO_RDATA[31:24];
    assign fetching = (state_q == ST_HDR) || (state_q == ST_ARG);
    assign pop      = fetching && !CMD_FIFO_EMPTY;

`ifdef DRW_CMDPARSE_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_q;

    // stall_q holds the number of earlier consecutive stall cycles, so the
    // cycle that finds it at TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th stall.
    assign timeout = fetching && CMD_FIFO_EMPTY &&
                     (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (rst || pop || !fetching || (state_d != state_q)) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (DRW_START) begin
                    state_d = ST_HDR;
                    err_d   = DRW_ERR_OK;
                end
            end
            ST_HDR: begin
                if (pop) begin
                    if (drw_op_illegal(hdr_op)) begin
                        state_d = ST_ERROR;
                        err_d   = DRW_ERR_ILLEGAL;
                    end else if (hdr_op == OP_EODL) begin
                        state_d = ST_DRAIN;
                    end else if (hdr_op == OP_NOP) begin
                        state_d = ST_HDR;
                    end else if (drw_arg_count(hdr_op) == 2'd0) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_ARG;
                    end
                end else if (timeout) begin
                    state_d = ST_ERROR;
                    err_d   = DRW_ERR_TIMEOUT;
                end
            end
            ST_ARG: begin
                if (pop) begin
                    if (arg_idx_q == arg_cnt_q - 2'd1) begin
                        state_d = ST_ISSUE;
                    end
                end else if (timeout) begin
                    state_d = ST_ERROR;
                    err_d   = DRW_ERR_TIMEOUT;
                end
            end
            ST_ISSUE: begin
                if (CMD_READY) begin
                    state_d = ST_HDR;
                end
            end
            ST_DRAIN: begin
                if (!ENGINE_BUSY) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            err_q     <= DRW_ERR_OK;
            op_q      <= '0;
            imm_q     <= '0;
            arg0_q    <= '0;
            arg1_q    <= '0;
            arg2_q    <= '0;
            arg_idx_q <= '0;
            arg_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == ST_HDR && pop) begin
                // Arguments are cleared here so that fields a shorter command
                // does not load read back as 0 rather than stale data.
                op_q      <= hdr_op;
                imm_q     <= CMD_FIFO_RDATA[23:0];
                arg_idx_q <= '0;
                arg_cnt_q <= drw_arg_count(hdr_op);
                arg0_q    <= '0;
                arg1_q    <= '0;
                arg2_q    <= '0;
            end
            if (state_q == ST_ARG && pop) begin
                case (arg_idx_q)
                    2'd0:    arg0_q <= CMD_FIFO_RDATA;
                    2'd1:    arg1_q <= CMD_FIFO_RDATA;
                    default: arg2_q <= CMD_FIFO_RDATA;
                endcase
                arg_idx_q <= arg_idx_q + 2'd1;
            end
        end
    end

    // Busy/IRQ follow the state directly; the IRQ cycle is the last cycle of
    // DRAIN (engine idle) or the single ERROR cycle, and busy is already low there.
    assign CMD_FIFO_RD = pop;
    assign CMD_VALID   = (state_q == ST_ISSUE);
    assign DRW_BUSY    = (state_q == ST_HDR) || (state_q == ST_ARG) ||
                         (state_q == ST_ISSUE) ||
                         ((state_q == ST_DRAIN) && ENGINE_BUSY);
    assign DRW_IRQ     = (state_q == ST_ERROR) ||
                         ((state_q == ST_DRAIN) && !ENGINE_BUSY);
    assign DRW_ERR     = err_q;
    assign CMD_OP      = op_q;
    assign CMD_IMM     = imm_q;
    assign CMD_ARG0    = arg0_q;
    assign CMD_ARG1    = arg1_q;
    assign CMD_ARG2    = arg2_q;

endmodule

// File: tb/tb_drw_cmdparse.sv
// tb/tb_drw_cmdparse.sv - self-checking bench for drw_cmdparse

module tb_drw_cmdparse;

    logic        CLK = 1'b0;
    logic        ARST = 1'b1;
    logic        SOFT_RST = 1'b0;
    logic        DRW_START = 1'b0;
    logic        CMD_FIFO_EMPTY = 1'b1;
    logic [31:0] CMD_FIFO_RDATA = 32'h0;
    logic        CMD_FIFO_RD;
    logic        CMD_VALID;
    logic        CMD_READY = 1'b1;
    logic [7:0]  CMD_OP;
    logic [23:0] CMD_IMM;
    logic [31:0] CMD_ARG0, CMD_ARG1, CMD_ARG2;
    logic        ENGINE_BUSY = 1'b0;
    logic        DRW_BUSY;
    logic        DRW_IRQ;
    logic [2:0]  DRW_ERR;

    always #5 CLK = ~CLK;

    drw_cmdparse #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .ARST(ARST), .SOFT_RST(SOFT_RST), .DRW_START(DRW_START),
        .CMD_FIFO_EMPTY(CMD_FIFO_EMPTY), .CMD_FIFO_RDATA(CMD_FIFO_RDATA),
        .CMD_FIFO_RD(CMD_FIFO_RD), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_IMM(CMD_IMM), .CMD_ARG0(CMD_ARG0),
        .CMD_ARG1(CMD_ARG1), .CMD_ARG2(CMD_ARG2), .ENGINE_BUSY(ENGINE_BUSY),
        .DRW_BUSY(DRW_BUSY), .DRW_IRQ(DRW_IRQ), .DRW_ERR(DRW_ERR)
    );

    typedef struct {
        logic [7:0]  op;
        logic [23:0] imm;
        logic [31:0] a0, a1, a2;
    } cmd_t;

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] a0, a1, a2;
        logic [2:0]  err;
        int          nissue;
        logic [31:0] e0, e1, e2;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] prog_q[$];
    cmd_t        issued[$];
    cmd_t        exp_q[$];
    int          exp_err, exp_left;
    int          irq_cnt = 0;
    int          rd_empty_viol = 0;
    bit          hold_empty = 0;
    bit          toggle_empty = 0;
    bit          rnd_mode = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive_fifo();
        CMD_FIFO_EMPTY = hold_empty || (fifo_q.size() == 0);
        CMD_FIFO_RDATA = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endtask

    // One clock: observe pops/transfers/IRQ just before the edge, then update
    // the FIFO model and any randomised inputs just after it.
    task automatic tick();
        cmd_t c;
        #1;
        if (CMD_FIFO_RD === 1'b1) begin
            if (CMD_FIFO_EMPTY || fifo_q.size() == 0) rd_empty_viol++;
            else void'(fifo_q.pop_front());
        end
        if (CMD_VALID === 1'b1 && CMD_READY) begin
            c.op = CMD_OP; c.imm = CMD_IMM;
            c.a0 = CMD_ARG0; c.a1 = CMD_ARG1; c.a2 = CMD_ARG2;
            issued.push_back(c);
        end
        if (DRW_IRQ === 1'b1) irq_cnt++;
        @(posedge CLK);
        #1;
        if (toggle_empty) hold_empty = !hold_empty;
        if (rnd_mode) begin
            hold_empty  = ($urandom_range(0, 3) == 0);
            CMD_READY   = 1'($urandom_range(0, 1));
            ENGINE_BUSY = ($urandom_range(0, 2) == 0);
        end
        drive_fifo();
    endtask

    task automatic start();
        DRW_START = 1'b1;
        tick();
        DRW_START = 1'b0;
    endtask

    task automatic wait_irq(input string name, input int budget, output int n);
        int c0;
        c0 = irq_cnt;
        n = 0;
        while (irq_cnt == c0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_irq_seen"}, (irq_cnt != c0), 1);
    endtask

    function automatic int nargs(input logic [7:0] op);
        case (op)
            8'h01, 8'h03: return 2;
            8'h04:        return 3;
            default:      return 0;
        endcase
    endfunction

    function automatic bit legal(input logic [7:0] op);
        return (op <= 8'h04) || (op == 8'h0F);
    endfunction

    // Walks prog_q by the command-list rules and produces the expected
    // issued commands, error code and count of words left unread.
    task automatic model();
        int          i, n;
        logic [31:0] w;
        logic [7:0]  op;
        cmd_t        c;
        exp_q = {};
        exp_err = 0;
        i = 0;
        while (i < prog_q.size()) begin
            w = prog_q[i];
            op = w[31:24];
            i++;
            if (!legal(op)) begin
                exp_err = 1;
                break;
            end
            if (op == 8'h0F) break;
            if (op == 8'h00) continue;
            c.op = op; c.imm = w[23:0]; c.a0 = 0; c.a1 = 0; c.a2 = 0;
            n = nargs(op);
            if (n > 0) c.a0 = prog_q[i];
            if (n > 1) c.a1 = prog_q[i + 1];
            if (n > 2) c.a2 = prog_q[i + 2];
            i += n;
            exp_q.push_back(c);
        end
        exp_left = prog_q.size() - i;
    endtask

    task automatic compare_cmds(input string name);
        check({name, "_count"}, issued.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < issued.size(); k++) begin
            check({name, "_op"},   issued[k].op,  exp_q[k].op);
            check({name, "_imm"},  issued[k].imm, exp_q[k].imm);
            check({name, "_arg0"}, issued[k].a0,  exp_q[k].a0);
            check({name, "_arg1"}, issued[k].a1,  exp_q[k].a1);
            check({name, "_arg2"}, issued[k].a2,  exp_q[k].a2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[9];
        int          n;
        logic [31:0] w;
        logic [7:0]  op;

        // ---------------- reset ----------------
        ARST = 1'b1;
        drive_fifo();
        tick(); tick();
        ARST = 1'b0;
        check("rst_busy", DRW_BUSY, 0);
        check("rst_irq", DRW_IRQ, 0);
        check("rst_valid", CMD_VALID, 0);
        check("rst_rd", CMD_FIFO_RD, 0);
        check("rst_err", DRW_ERR, 0);
        check("rst_op", CMD_OP, 0);
        check("rst_imm", CMD_IMM, 0);
        check("rst_arg0", CMD_ARG0, 0);

        // ---------------- reset wins over start ----------------
        fifo_q = {32'h0200_0001, 32'h0F00_0000};
        drive_fifo();
        ARST = 1'b1; DRW_START = 1'b1;
        tick();
        ARST = 1'b0; DRW_START = 1'b0;
        check("rstwin_busy", DRW_BUSY, 0);
        tick();
        check("rstwin_rd", CMD_FIFO_RD, 0);
        fifo_q = {};
        drive_fifo();

        // ---------------- SETCOLOR then EODL ----------------
        fifo_q = {32'h0200_FF00, 32'h0F00_0000};
        drive_fifo();
        issued = {}; irq_cnt = 0;
        start();
        check("sc_busy_after_start", DRW_BUSY, 1);
        check("sc_hdr_pop", CMD_FIFO_RD, 1);
        tick();
        check("sc_valid_n1", CMD_VALID, 1);
        check("sc_op", CMD_OP, 32'h02);
        check("sc_imm", CMD_IMM, 32'h00FF00);
        wait_irq("sc", 50, n);
        check("sc_issues", issued.size(), 1);
        if (issued.size() == 1) begin
            check("sc_iss_op", issued[0].op, 32'h02);
            check("sc_iss_arg0", issued[0].a0, 0);
            check("sc_iss_arg2", issued[0].a2, 0);
        end
        tick();
        check("sc_irq_once", irq_cnt, 1);
        check("sc_busy_end", DRW_BUSY, 0);
        check("sc_err", DRW_ERR, 0);

        // ---------------- BITBLT with READY held low ----------------
        fifo_q = {32'h0400_0123, 32'h11, 32'h22, 32'h33, 32'h0F00_0000};
        drive_fifo();
        issued = {}; irq_cnt = 0;
        CMD_READY = 1'b0;
        start();
        tick(); tick(); tick();
        check("bb_valid_before_last", CMD_VALID, 0);
        tick();
        check("bb_valid_after_last", CMD_VALID, 1);
        for (int i = 0; i < 5; i++) begin
            check("bb_hold_valid", CMD_VALID, 1);
            check("bb_hold_op", CMD_OP, 32'h04);
            check("bb_hold_imm", CMD_IMM, 32'h000123);
            check("bb_hold_arg0", CMD_ARG0, 32'h11);
            check("bb_hold_arg1", CMD_ARG1, 32'h22);
            check("bb_hold_arg2", CMD_ARG2, 32'h33);
            tick();
        end
        check("bb_no_transfer", issued.size(), 0);
        CMD_READY = 1'b1;
        check("bb_valid_at_ready", CMD_VALID, 1);
        tick();
        check("bb_transfer", issued.size(), 1);
        check("bb_valid_drop", CMD_VALID, 0);
        wait_irq("bb", 50, n);

        // ---------------- PATBLT with EMPTY toggling ----------------
        tick();
        fifo_q = {32'h0300_ABCD, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0F00_0000};
        issued = {}; irq_cnt = 0;
        rd_empty_viol = 0;
        hold_empty = 1'b0;
        drive_fifo();
        toggle_empty = 1'b1;
        start();
        wait_irq("pb", 100, n);
        toggle_empty = 1'b0; hold_empty = 1'b0;
        drive_fifo();
        check("pb_rd_while_empty", rd_empty_viol, 0);
        check("pb_issues", issued.size(), 1);
        if (issued.size() == 1) begin
            check("pb_op", issued[0].op, 32'h03);
            check("pb_arg0", issued[0].a0, 32'hAAAA_0001);
            check("pb_arg1", issued[0].a1, 32'hBBBB_0002);
            check("pb_arg2", issued[0].a2, 0);
        end

        // ---------------- illegal opcode 0x07 ----------------
        tick();
        fifo_q = {32'h0700_0000, 32'h0200_0001};
        drive_fifo();
        issued = {}; irq_cnt = 0;
        start();
        wait_irq("ill", 20, n);
        check("ill_err", DRW_ERR, 3'b001);
        check("ill_busy", DRW_BUSY, 0);
        tick(); tick();
        check("ill_left_unread", fifo_q.size(), 1);
        check("ill_no_issue", issued.size(), 0);
        check("ill_err_holds", DRW_ERR, 3'b001);
        fifo_q = {};
        drive_fifo();

        // ---------------- EODL while engine busy ----------------
        fifo_q = {32'h0F00_0000};
        drive_fifo();
        ENGINE_BUSY = 1'b1;
        irq_cnt = 0;
        start();
        check("eodl_err_cleared", DRW_ERR, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            DRW_START = (i == 4);
            tick();
        end
        DRW_START = 1'b0;
        check("eodl_no_early_irq", irq_cnt, 0);
        check("eodl_busy_during", DRW_BUSY, 1);
        ENGINE_BUSY = 1'b0;
        wait_irq("eodl", 5, n);
        tick(); tick(); tick();
        check("eodl_irq_once", irq_cnt, 1);
        check("eodl_busy_after", DRW_BUSY, 0);

        // ---------------- SOFT_RST mid-ARG ----------------
        fifo_q = {32'h0400_0777, 32'h5555_5555};
        drive_fifo();
        irq_cnt = 0;
        start();
        tick(); tick(); tick();
        check("srst_mid_arg0", CMD_ARG0, 32'h5555_5555);
        check("srst_mid_busy", DRW_BUSY, 1);
        SOFT_RST = 1'b1;
        tick();
        SOFT_RST = 1'b0;
        check("srst_busy", DRW_BUSY, 0);
        check("srst_valid", CMD_VALID, 0);
        check("srst_rd", CMD_FIFO_RD, 0);
        check("srst_irq", DRW_IRQ, 0);
        check("srst_err", DRW_ERR, 0);
        check("srst_op", CMD_OP, 0);
        check("srst_imm", CMD_IMM, 0);
        check("srst_arg0", CMD_ARG0, 0);
        fifo_q = {32'h0200_0001};
        drive_fifo();
        tick(); tick();
        check("srst_stays_idle", DRW_BUSY, 0);
        check("srst_fifo_kept", fifo_q.size(), 1);
        check("srst_no_irq", irq_cnt, 0);
        fifo_q = {};
        drive_fifo();

        // ---------------- single-command table ----------------
        tbl[0] = '{32'h0112_3456, 32'hA1, 32'hA2, 32'hA3, 3'd0, 1, 32'hA1, 32'hA2, 32'h0};
        tbl[1] = '{32'h02AB_CDEF, 32'hA1, 32'hA2, 32'hA3, 3'd0, 1, 32'h0,  32'h0,  32'h0};
        tbl[2] = '{32'h0300_0001, 32'hB1, 32'hB2, 32'hB3, 3'd0, 1, 32'hB1, 32'hB2, 32'h0};
        tbl[3] = '{32'h04FF_FFFF, 32'hC1, 32'hC2, 32'hC3, 3'd0, 1, 32'hC1, 32'hC2, 32'hC3};
        tbl[4] = '{32'h0000_0000, 32'h0,  32'h0,  32'h0,  3'd0, 0, 32'h0,  32'h0,  32'h0};
        tbl[5] = '{32'h0500_0000, 32'h0,  32'h0,  32'h0,  3'd1, 0, 32'h0,  32'h0,  32'h0};
        tbl[6] = '{32'h0E00_0000, 32'h0,  32'h0,  32'h0,  3'd1, 0, 32'h0,  32'h0,  32'h0};
        tbl[7] = '{32'h1000_0000, 32'h0,  32'h0,  32'h0,  3'd1, 0, 32'h0,  32'h0,  32'h0};
        tbl[8] = '{32'hFF00_0000, 32'h0,  32'h0,  32'h0,  3'd1, 0, 32'h0,  32'h0,  32'h0};
        for (int v = 0; v < 9; v++) begin
            w = tbl[v].hdr;
            op = w[31:24];
            fifo_q = {w};
            if (nargs(op) > 0) fifo_q.push_back(tbl[v].a0);
            if (nargs(op) > 1) fifo_q.push_back(tbl[v].a1);
            if (nargs(op) > 2) fifo_q.push_back(tbl[v].a2);
            fifo_q.push_back(32'h0F00_0000);
            drive_fifo();
            issued = {}; irq_cnt = 0;
            start();
            wait_irq($sformatf("tbl%0d", v), 50, n);
            tick();
            check($sformatf("tbl%0d_err", v), DRW_ERR, tbl[v].err);
            check($sformatf("tbl%0d_issues", v), issued.size(), tbl[v].nissue);
            check($sformatf("tbl%0d_left", v), fifo_q.size(), (tbl[v].err != 0) ? 1 : 0);
            if (issued.size() == 1) begin
                check($sformatf("tbl%0d_op", v), issued[0].op, op);
                check($sformatf("tbl%0d_imm", v), issued[0].imm, w[23:0]);
                check($sformatf("tbl%0d_arg0", v), issued[0].a0, tbl[v].e0);
                check($sformatf("tbl%0d_arg1", v), issued[0].a1, tbl[v].e1);
                check($sformatf("tbl%0d_arg2", v), issued[0].a2, tbl[v].e2);
            end
            fifo_q = {};
            drive_fifo();
        end

        // ---------------- randomised command lists ----------------
        rd_empty_viol = 0;
        for (int p = 0; p < 25; p++) begin
            prog_q = {};
            for (int k = 0; k < $urandom_range(1, 6); k++) begin
                if ($urandom_range(0, 19) == 0) op = 8'($urandom_range(5, 14));
                else op = 8'($urandom_range(0, 4));
                prog_q.push_back({op, 24'($urandom)});
                for (int a = 0; a < (legal(op) ? nargs(op) : 2); a++)
                    prog_q.push_back($urandom);
            end
            prog_q.push_back(32'h0F00_0000);
            for (int j = 0; j < $urandom_range(0, 2); j++) prog_q.push_back($urandom);
            model();
            fifo_q = prog_q;
            issued = {}; irq_cnt = 0;
            drive_fifo();
            rnd_mode = 1'b1;
            start();
            wait_irq($sformatf("rnd%0d", p), 2000, n);
            rnd_mode = 1'b0;
            hold_empty = 1'b0; CMD_READY = 1'b1; ENGINE_BUSY = 1'b0;
            drive_fifo();
            tick();
            check($sformatf("rnd%0d_err", p), DRW_ERR, exp_err);
            check($sformatf("rnd%0d_left", p), fifo_q.size(), exp_left);
            check($sformatf("rnd%0d_irq_once", p), irq_cnt, 1);
            compare_cmds($sformatf("rnd%0d", p));
            fifo_q = {};
            drive_fifo();
        end
        check("rnd_rd_while_empty", rd_empty_viol, 0);

        // ---------------- empty FIFO after start ----------------
        fifo_q = {};
        drive_fifo();
        irq_cnt = 0;
`ifdef DRW_CMDPARSE_TIMEOUT_EN
        start();
        wait_irq("tmo", 100, n);
        check("tmo_cycles", n, 17);
        check("tmo_err", DRW_ERR, 3'b010);
        check("tmo_busy", DRW_BUSY, 0);
`else
        start();
        for (int i = 0; i < 100; i++) tick();
        check("stall_no_irq", irq_cnt, 0);
        check("stall_busy", DRW_BUSY, 1);
        check("stall_err", DRW_ERR, 0);
        SOFT_RST = 1'b1;
        tick();
        SOFT_RST = 1'b0;
        check("stall_srst_busy", DRW_BUSY, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
